clk_switch_ctrl: RTL
====================

// Module: clk_switch_ctrl
// PURPOSE
//  Sequencer for the two-input glitch-free clock mux: arbitrates clock-switch requests from NREQ requesters,
//  drives the mux select, tracks break-before-make via per-source status, enforces a minimum dwell, then acks.
//  Runs on an always-on control clock, independent of the two muxed clocks.
// PARAMETERS
//  NREQ         2    number of requesters (>=1); fixed priority, index 0 highest
//  SYNC_STAGES  2    flops per status synchroniser (>=2)
//  DWELL_CYC    16   clk cycles held after the new source is on, before ack (>=1)
//  TIMEOUT_CYC  256  clk cycles allowed in BREAK+MAKE (used only with CLKSW_TIMEOUT_EN)
// PORTS
//  clk      in   1     always-on control clock; all state on posedge clk
//  rst_n    in   1     asynchronous reset, active low
//  req      in   NREQ  level switch request; held until matching ack
//  req_sel  in   NREQ  requested source per requester (0=clk0, 1=clk1); stable while req high
//  ack      out  NREQ  one-cycle completion pulse to the granted requester
//  err      out  1     one-cycle pulse coincident with ack when the switch failed (timeout)
//  select   out  1     to mux select input
//  clk0_on  in   1     async status: clk0 path enabled in mux (second-stage enable flop)
//  clk1_on  in   1     async status: clk1 path enabled in mux
//  cur_sel  out  1     committed source
//  busy     out  1     high in any state other than IDLE
// BEHAVIOUR
//  - Reset values: select=0, cur_sel=0, ack=0, err=0, busy=0, state=IDLE, all counters 0. Reset mid-switch
//    aborts immediately; mux reverts to clk0; no ack is issued for the aborted request.
//  - Status inputs pass through SYNC_STAGES synchronisers; on0_s/on1_s lag by SYNC_STAGES cycles.
//  - States: IDLE, BREAK, MAKE, DWELL, ACK.
//  - IDLE: grant g = lowest index with req high. If req_sel[g]==cur_sel -> ACK next cycle, select unchanged.
//    Otherwise latch g and tgt=req_sel[g], select<=tgt, -> BREAK. No request: stay.
//  - BREAK: wait until old-source status (on[cur_sel]_s) is 0 -> MAKE.
//  - MAKE: wait until new-source status (on[tgt]_s) is 1; cur_sel<=tgt, load dwell counter -> DWELL.
//  - DWELL: count DWELL_CYC cycles -> ACK. ACK: ack[g]=1 for exactly one cycle -> IDLE.
//  - Arbitration happens only in IDLE; requests arriving while busy wait. A req still high in the cycle
//    after ACK is re-arbitrated (requester must drop req on ack). A req dropped before ack: sequence still
//    completes and the ack pulse is issued.
//  - ack is one-hot or zero; never two acks in consecutive cycles for different grants without an IDLE cycle.
//  - Minimum switch latency, req to ack: 1 + 2*SYNC_STAGES + DWELL_CYC + 1 cycles; same-source request acks 2 cycles after req.
// CONFIGURATION
//  CLKSW_TIMEOUT_EN defined: counter runs in BREAK+MAKE; on reaching TIMEOUT_CYC: select<=cur_sel (revert),
//    cur_sel unchanged, -> ACK with err=1. Counter cleared on entry to BREAK.
//  Not defined: BREAK/MAKE wait indefinitely; err tied 0; no timeout counter.
// STRUCTURE
//  - Package clk_switch_pkg: state enum (IDLE, BREAK, MAKE, DWELL, ACK), counter-width function ($clog2-based).
//  - Sub-module clk_sw_sync: SYNC_STAGES-deep synchroniser, async-reset to 0; two instances (clk0_on, clk1_on).
//  - Arbiter, FSM and counters live in clk_switch_ctrl.
// TESTING
//  1. Reset release, no req: select=0, cur_sel=0, busy=0, ack=0 indefinitely.
//  2. req[0]=1, req_sel[0]=1, mux model drops clk0_on then raises clk1_on: select=1 next cycle,
//     cur_sel=1 after clk1_on seen, ack[0] pulses once DWELL_CYC=16 cycles later, err=0.
//  3. req[1]=1 with req_sel[1]=cur_sel: ack[1] pulses 2 cycles after req, select never toggles.
//  4. req[0] and req[1] raised same cycle (targets 1 and 0): req[0] served first, req[1] served after,
//     final cur_sel=0, acks in order 0 then 1.
//  5. CLKSW_TIMEOUT_EN, TIMEOUT_CYC=256, clk1_on held 0: select returns to 0 after 256 cycles,
//     ack and err pulse together, cur_sel stays 0; without macro, busy stays 1.
//  6. rst_n asserted during DWELL: all outputs return to reset values asynchronously, no ack after release.

Source files
------------

// File: rtl/clk_switch_pkg.sv
// ---------------------------------------------------------------------------
// Package: clk_switch_pkg
// Purpose: Shared types and helpers for the glitch-free clock-mux sequencer.
//   - clksw_state_e : sequencer state encoding (IDLE, BREAK, MAKE, DWELL, ACK)
//   - cnt_width()   : bit width needed to hold a counter value 0..max_val
// ---------------------------------------------------------------------------
package clk_switch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BREAK = 3'd1,
        MAKE  = 3'd2,
        DWELL = 3'd3,
        ACK   = 3'd4
    } clksw_state_e;

    // Width of a counter that must represent every value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_sw_sync.sv
// ---------------------------------------------------------------------------
// Module: clk_sw_sync
// Purpose: Multi-flop synchroniser bringing an asynchronous mux status bit
//          into the control clock domain. All flops reset to 0.
// Parameters:
//   STAGES  number of flops in the chain (>= 2)
// Ports:
//   clk    in  control clock
//   rst_n  in  asynchronous reset, active low
//   d      in  asynchronous input
//   q      out synchronised output, lags d by STAGES cycles
// ---------------------------------------------------------------------------
module clk_sw_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// ---------------------------------------------------------------------------
// Module: clk_switch_ctrl
// Purpose: Sequencer for a two-input glitch-free clock mux. Arbitrates switch
//          requests (fixed priority, index 0 highest), drives the mux select,
//          waits for the old source to stop (break) and the new source to
//          start (make) using synchronised mux status, holds a minimum dwell,
//          then acknowledges the granted requester.
//
// Optional feature macro: CLKSW_TIMEOUT_EN
//   Defined     : BREAK+MAKE are bounded by TIMEOUT_CYC cycles; on expiry the
//                 select reverts to cur_sel and the ack carries err=1.
//   Not defined : BREAK/MAKE wait indefinitely, err is tied to 0.
//
// Handshake (req/ack): req[i] is a level held high until ack[i] pulses; while
//   req[i] is high req_sel[i] must be stable. ack[i] is a single-cycle pulse.
//   The requester must drop req[i] in the cycle ack[i] is seen, otherwise it
//   is arbitrated again. Dropping req early does not cancel the sequence.
//
// Ports:
//   clk        in   control clock (always on)
//   rst_n      in   asynchronous reset, active low
//   req        in   [NREQ] switch request levels
//   req_sel    in   [NREQ] requested source per requester (0=clk0, 1=clk1)
//   ack        out  [NREQ] one-cycle completion pulse, one-hot or zero
//   err        out  one-cycle failure flag, coincident with ack
//   select     out  mux select
//   clk0_on    in   async status: clk0 path enabled in the mux
//   clk1_on    in   async status: clk1 path enabled in the mux
//   cur_sel    out  committed source
//   busy       out  high whenever the sequencer is not IDLE
//   state_dbg  out  current sequencer state
// ---------------------------------------------------------------------------
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DWELL_CYC   = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_sel,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              select,
    input  logic              clk0_on,
    input  logic              clk1_on,
    output logic              cur_sel,
    output logic              busy,
    output clksw_state_e      state_dbg
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // DWELL and BREAK/MAKE never overlap, so one counter serves both the
    // dwell count and (when enabled) the timeout.
    localparam int CW = (cnt_width(DWELL_CYC) > cnt_width(TIMEOUT_CYC)) ?
                        cnt_width(DWELL_CYC) : cnt_width(TIMEOUT_CYC);

    clksw_state_e   state;
    logic [GW-1:0]  gnt_q;
    logic           tgt_q;
    logic [CW-1:0]  cnt;

    logic           on0_s;
    logic           on1_s;
    logic           old_on_s;
    logic           new_on_s;

    logic           any_req;
    logic [GW-1:0]  grant_idx;

    // -----------------------------------------------------------------------
    // Status synchronisers
    // -----------------------------------------------------------------------
    clk_sw_sync #(.STAGES(SYNC_STAGES)) u_sync_on0 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk0_on),
        .q     (on0_s)
    );

    clk_sw_sync #(.STAGES(SYNC_STAGES)) u_sync_on1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk1_on),
        .q     (on1_s)
    );

    // Old source is the committed one; new source is the latched target.
    assign old_on_s = cur_sel ? on1_s : on0_s;
    assign new_on_s = tgt_q   ? on1_s : on0_s;

    // -----------------------------------------------------------------------
    // Fixed-priority arbiter: lowest index wins. Scanning downwards lets the
    // last hit (lowest index) overwrite higher ones.
    // -----------------------------------------------------------------------
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req   = 1'b1;
                grant_idx = GW'(i);
            end
        end
    end

    assign state_dbg = state;

`ifdef CLKSW_TIMEOUT_EN
    logic fail_q;
`else
    assign err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            select  <= 1'b0;
            cur_sel <= 1'b0;
            ack     <= '0;
            busy    <= 1'b0;
            gnt_q   <= '0;
            tgt_q   <= 1'b0;
            cnt     <= '0;
`ifdef CLKSW_TIMEOUT_EN
            err     <= 1'b0;
            fail_q  <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef CLKSW_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q <= grant_idx;
                        tgt_q <= req_sel[grant_idx];
                        busy  <= 1'b1;
`ifdef CLKSW_TIMEOUT_EN
                        fail_q <= 1'b0;
`endif
                        if (req_sel[grant_idx] == cur_sel) begin
                            // Already on the requested source: just ack.
                            state <= ACK;
                        end else begin
                            select <= req_sel[grant_idx];
                            cnt    <= '0;
                            state  <= BREAK;
                        end
                    end
                end

                BREAK: begin
`ifdef CLKSW_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
                    if (cnt >= CW'(TIMEOUT_CYC - 1)) begin
                        select <= cur_sel;
                        fail_q <= 1'b1;
                        state  <= ACK;
                    end else if (!old_on_s) begin
                        state <= MAKE;
                    end
`else
                    if (!old_on_s) begin
                        state <= MAKE;
                    end
`endif
                end

                MAKE: begin
                    if (new_on_s) begin
                        cur_sel <= tgt_q;
                        cnt     <= CW'(DWELL_CYC - 1);
                        state   <= DWELL;
`ifdef CLKSW_TIMEOUT_EN
                    end else if (cnt >= CW'(TIMEOUT_CYC - 1)) begin
                        select <= cur_sel;
                        fail_q <= 1'b1;
                        state  <= ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end

                DWELL: begin
                    if (cnt == '0) begin
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ACK: begin
                    ack[gnt_q] <= 1'b1;
`ifdef CLKSW_TIMEOUT_EN
                    err <= fail_q;
`endif
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
